result_tx_sequencer: RTL and testbench

- Streams a computed result buffer out through the UART transmitter, one byte at a time, under a start/done handshake.
- Sits between the coprocessor result memory (synchronous-read port) and the UART TX core.
- Parametrised successor of the fixed 1024-byte sender:
  - length set per transfer at run time
  - multi-byte words serialised with selectable byte order
  - abort support
  - explicit busy/done reporting

---
 rtl/result_tx_sequencer_if.sv | 31 +++
 rtl/result_tx_sequencer.sv | 155 +++++++++++++++
 tb/tb_result_tx_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_tx_sequencer_if.sv
// Bus bundle between the result sequencer, the result buffer read port,
// the UART TX core and the controlling start/done logic.
interface result_tx_sequencer_if #(
    parameter int NUM_WORDS  = 1024,
    parameter int WORD_BYTES = 1
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int LW = AW + 1;

    logic                    start;
    logic [LW-1:0]           length;
    logic                    abort;
    logic [AW-1:0]           rd_addr;
    logic                    rd_en;
    logic [8*WORD_BYTES-1:0] rd_data;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, length, abort, rd_data, tx_busy,
        output rd_addr, rd_en, tx_data, tx_start, busy, done
    );

    modport slave (
        output start, length, abort, rd_data, tx_busy,
        input  rd_addr, rd_en, tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/result_tx_sequencer.sv
// Streams result buffer words out through the UART, one byte at a time,
// with run-time length, selectable byte order, abort and busy/done status.
module result_tx_sequencer #(
    parameter int NUM_WORDS  = 1024,
    parameter int WORD_BYTES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    result_tx_sequencer_if.master bus
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int LW = AW + 1;
    localparam int DW = 8 * WORD_BYTES;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_HOLD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [LW-1:0]   len_q;
    logic [AW-1:0]   word_q;
    logic [BW-1:0]   byte_q;
    logic [DW-1:0]   shreg_q;
    logic [AW-1:0]   rd_addr_q;
    logic            rd_en_q;
    logic [7:0]      tx_data_q;
    logic            tx_start_q;
    logic            busy_q;
    logic            done_q;

    logic [LW-1:0]   len_d;
    logic [7:0]      byte_d;
    logic            last_byte_d;
    logic            more_words_d;
    int unsigned     idx_d;

    // Clamp the requested length, pick the outgoing byte, and find transfer edges.
    always_comb begin
        len_d = bus.length;
        if (bus.length > LW'(NUM_WORDS)) begin
            len_d = LW'(NUM_WORDS);
        end
        idx_d = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(byte_q))
                                 : int'(byte_q);
        byte_d       = shreg_q[8*idx_d +: 8];
        last_byte_d  = (int'(byte_q) == WORD_BYTES - 1);
        more_words_d = ((LW'(word_q) + LW'(1)) < len_q);
    end

    // Transfer FSM with all outputs registered; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_q     <= '0;
            byte_q     <= '0;
            shreg_q    <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (state_q != S_IDLE && bus.abort) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            byte_q     <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        len_q     <= len_d;
                        busy_q    <= 1'b1;
                        word_q    <= '0;
                        byte_q    <= '0;
                        rd_addr_q <= '0;
                        rd_en_q   <= (len_d != '0);
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    if (len_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    shreg_q <= bus.rd_data;
                    byte_q  <= '0;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= byte_d;
                        tx_start_q <= 1'b1;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (!last_byte_d) begin
                            byte_q  <= byte_q + BW'(1);
                            state_q <= S_SEND;
                        end else if (more_words_d) begin
                            word_q    <= word_q + AW'(1);
                            rd_addr_q <= word_q + AW'(1);
                            rd_en_q   <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_result_tx_sequencer.sv
// Scoreboard bench for result_tx_sequencer: three configurations sharing
// one clock, each with its own result buffer and UART busy model.
module tb_result_tx_sequencer;
    localparam int UART_CYC = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] start_s, abort_s, hold_s;
    logic [2:0][10:0] len_s;
    logic [2:0] tx_start_w, busy_w, done_w, rd_en_w, tx_busy_w;
    logic [2:0][7:0] tx_data_w;
    logic [2:0][9:0] rd_addr_w;
    logic [15:0] mem [3][1024];

    int tests = 0;
    int fails = 0;
    int st_cnt [3];
    int re_cnt [3];
    int dn_cnt [3];
    int last_addr [3];

    logic [7:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int NW  = (k == 0) ? 1024 : 8;
        localparam int WB  = (k == 0) ? 1 : 2;
        localparam int MSB = (k == 2) ? 1 : 0;
        localparam int LW  = $clog2(NW) + 1;

        logic [15:0] rdq;
        int cnt;

        result_tx_sequencer_if #(.NUM_WORDS(NW), .WORD_BYTES(WB)) bus ();

        result_tx_sequencer #(
            .NUM_WORDS(NW), .WORD_BYTES(WB), .MSB_FIRST(MSB)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.master)
        );

        always @(posedge clk) begin
            if (bus.rd_en) rdq <= mem[k][bus.rd_addr];
        end

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= 0;
            else if (bus.tx_start) cnt <= UART_CYC;
            else if (cnt > 0) cnt <= cnt - 1;
        end

        assign bus.start   = start_s[k];
        assign bus.abort   = abort_s[k];
        assign bus.length  = len_s[k][LW-1:0];
        assign bus.rd_data = rdq[8*WB-1:0];
        assign bus.tx_busy = (cnt != 0) | hold_s[k];

        assign tx_start_w[k] = bus.tx_start;
        assign tx_data_w[k]  = bus.tx_data;
        assign busy_w[k]     = bus.busy;
        assign done_w[k]     = bus.done;
        assign rd_en_w[k]    = bus.rd_en;
        assign tx_busy_w[k]  = bus.tx_busy;
        assign rd_addr_w[k]  = 10'(bus.rd_addr);
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int k, input logic [7:0] b);
        case (k)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_clear(input int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic sb_check(input int k, input logic [7:0] act);
        logic [7:0] e;
        if (sb_size(k) == 0) begin
            chk($sformatf("sb_unexpected_tx%0d", k), 1, 0);
        end else begin
            case (k)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("sb_byte%0d", k), act, e);
        end
    endtask

    // Monitor: scoreboard compare on every tx_start, plus event counters.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (rd_en_w[k]) begin
                    re_cnt[k]++;
                    last_addr[k] = int'(rd_addr_w[k]);
                end
                if (tx_start_w[k]) begin
                    st_cnt[k]++;
                    chk($sformatf("busy_at_tx%0d", k), busy_w[k], 1);
                    sb_check(k, tx_data_w[k]);
                end
                if (done_w[k]) begin
                    dn_cnt[k]++;
                    chk($sformatf("done_after_txbusy%0d", k), tx_busy_w[k], 0);
                    chk($sformatf("sb_empty_at_done%0d", k), sb_size(k), 0);
                end
            end
        end
    end

    task automatic go(input int k, input int len);
        @(negedge clk);
        start_s[k] = 1'b1;
        len_s[k]   = 11'(len);
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int base, input int budget,
                             input string nm);
        int n = 0;
        while (dn_cnt[k] == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(dn_cnt[k] != base), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int k, input int budget, input string nm);
        int n = 0;
        while (!tx_start_w[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(tx_start_w[k]), 1);
    endtask

    task automatic chk_idle_outs(input int k, input string nm);
        chk({nm, "_busy"}, busy_w[k], 0);
        chk({nm, "_done"}, done_w[k], 0);
        chk({nm, "_txs"}, tx_start_w[k], 0);
        chk({nm, "_rden"}, rd_en_w[k], 0);
        chk({nm, "_addr"}, int'(rd_addr_w[k]), 0);
        chk({nm, "_txd"}, int'(tx_data_w[k]), 0);
    endtask

    initial begin
        int bs, bd, br;
        rst_n   = 1'b0;
        start_s = '0;
        abort_s = '0;
        hold_s  = '0;
        len_s   = '0;
        for (int k = 0; k < 3; k++) begin
            st_cnt[k] = 0; re_cnt[k] = 0; dn_cnt[k] = 0; last_addr[k] = -1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_idle_outs(k, $sformatf("reset%0d", k));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-byte words, three bytes.
        mem[0][0] = 16'h0011; mem[0][1] = 16'h0022; mem[0][2] = 16'h0033;
        sb_push(0, 8'h11); sb_push(0, 8'h22); sb_push(0, 8'h33);
        bs = st_cnt[0]; bd = dn_cnt[0];
        go(0, 3);
        wait_done(0, bd, 300, "t1_done");
        chk("t1_txcount", st_cnt[0] - bs, 3);
        chk("t1_donecount", dn_cnt[0] - bd, 1);

        // Two-byte words in both byte orders.
        mem[1][0] = 16'hA1B2; mem[1][1] = 16'hC3D4;
        mem[2][0] = 16'hA1B2; mem[2][1] = 16'hC3D4;
        sb_push(1, 8'hB2); sb_push(1, 8'hA1); sb_push(1, 8'hD4); sb_push(1, 8'hC3);
        sb_push(2, 8'hA1); sb_push(2, 8'hB2); sb_push(2, 8'hC3); sb_push(2, 8'hD4);
        bd = dn_cnt[2];
        @(negedge clk);
        start_s = 3'b110; len_s[1] = 11'd2; len_s[2] = 11'd2;
        @(negedge clk);
        start_s = 3'b000;
        wait_done(2, bd, 300, "t2_done_msb");
        chk("t2_tx_lsb", st_cnt[1], 4);
        chk("t2_tx_msb", st_cnt[2], 4);
        chk("t2_done_lsb", dn_cnt[1], 1);

        // Zero length: one busy cycle, then done, nothing read or sent.
        bs = st_cnt[0]; bd = dn_cnt[0]; br = re_cnt[0];
        @(negedge clk);
        start_s[0] = 1'b1; len_s[0] = 11'd0;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("t3_busy1", busy_w[0], 1);
        chk("t3_done1", done_w[0], 0);
        @(negedge clk);
        chk("t3_done2", done_w[0], 1);
        chk("t3_busy2", busy_w[0], 0);
        @(negedge clk);
        chk("t3_done3", done_w[0], 0);
        repeat (3) @(negedge clk);
        chk("t3_rden", re_cnt[0] - br, 0);
        chk("t3_txs", st_cnt[0] - bs, 0);
        chk("t3_donecount", dn_cnt[0] - bd, 1);

        // Over-long request clamps to the full buffer.
        for (int i = 0; i < 1024; i++) begin
            mem[0][i] = 16'((i * 7 + 3) & 255);
            sb_push(0, 8'((i * 7 + 3) & 255));
        end
        bs = st_cnt[0]; bd = dn_cnt[0]; br = re_cnt[0];
        go(0, 2000);
        wait_done(0, bd, 30000, "t4_done");
        chk("t4_txcount", st_cnt[0] - bs, 1024);
        chk("t4_rdcount", re_cnt[0] - br, 1024);
        chk("t4_lastaddr", last_addr[0], 1023);

        // UART busy before start holds off the first byte.
        hold_s[0] = 1'b1;
        mem[0][0] = 16'h007E;
        sb_push(0, 8'h7E);
        bs = st_cnt[0]; bd = dn_cnt[0];
        go(0, 1);
        repeat (50) @(negedge clk);
        chk("t5_held", st_cnt[0] - bs, 0);
        hold_s[0] = 1'b0;
        wait_done(0, bd, 100, "t5_done");
        chk("t5_txcount", st_cnt[0] - bs, 1);

        // Abort two cycles after the second byte launches.
        for (int i = 0; i < 5; i++) mem[0][i] = 16'(8'h01 + i);
        sb_push(0, 8'h01); sb_push(0, 8'h02);
        bs = st_cnt[0]; bd = dn_cnt[0];
        go(0, 5);
        wait_tx(0, 100, "t6_tx1");
        @(negedge clk);
        wait_tx(0, 100, "t6_tx2");
        repeat (2) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("t6_busy_off", busy_w[0], 0);
        repeat (40) @(negedge clk);
        chk("t6_no_more_tx", st_cnt[0] - bs, 2);
        chk("t6_no_done", dn_cnt[0] - bd, 0);
        sb_push(0, 8'h01);
        bd = dn_cnt[0];
        go(0, 1);
        wait_done(0, bd, 100, "t6_restart_done");
        chk("t6_restart_addr", last_addr[0], 0);

        // Second start mid-transfer is ignored.
        for (int i = 0; i < 3; i++) sb_push(0, 8'(mem[0][i]));
        bs = st_cnt[0]; bd = dn_cnt[0];
        go(0, 3);
        wait_tx(0, 100, "t7_tx1");
        go(0, 5);
        wait_done(0, bd, 300, "t7_done");
        chk("t7_txcount", st_cnt[0] - bs, 3);
        chk("t7_donecount", dn_cnt[0] - bd, 1);

        // Reset mid-transfer returns everything to idle without done.
        for (int i = 0; i < 3; i++) sb_push(0, 8'(mem[0][i]));
        bd = dn_cnt[0];
        go(0, 3);
        wait_tx(0, 100, "t8_tx1");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle_outs(0, "t8_rst");
        sb_clear(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t8_no_done", dn_cnt[0] - bd, 0);
        chk("t8_busy", busy_w[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
